// File: rtl/sw_handshake_ctrl.sv
// Switch-handshake sequencer: synchronises board switches, debounces the handshake
// bit, captures the data byte on each debounced rising edge and stalls the PC on waits.
module sw_handshake_ctrl #(
  parameter int N        = 8,
  parameter int HS_BIT   = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [9:0]   switchesIn,
  input  logic         waitReq,
  input  logic         waitLevel,
  output logic         stall,
  output logic         hsLevel,
  output logic [N-1:0] swData,
  output logic         swValid,
  output logic         waiting
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  typedef enum logic {IDLE, WAITING} state_t;

  logic [9:0]    s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hs_q, hs_d;
  logic [N-1:0]  data_q, data_d;
  logic          valid_q, valid_d;
  state_t        state_q, state_d;
  logic          hs_rise;
  logic          unused_sw;

  // Only the handshake and data bits are consumed; the rest are synchronised anyway.
  assign unused_sw = ^s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      cnt_q   <= '0;
      hs_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      s1_q    <= switchesIn;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      hs_q    <= hs_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  // Counter measures how long s2 has disagreed with the debounced level.
  always_comb begin
    cnt_d = '0;
    hs_d  = hs_q;
    if (s2_q[HS_BIT] != hs_q) begin
      if (cnt_q == CNT_LAST) hs_d = ~hs_q;
      else                   cnt_d = cnt_q + CW'(1);
    end
  end

  assign hs_rise = hs_d & ~hs_q;

  always_comb begin
    data_d  = data_q;
    valid_d = hs_rise;
    if (hs_rise) data_d = s2_q[N-1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (waitReq && (hs_q != waitLevel)) state_d = WAITING;
      WAITING: if (!waitReq || (hs_q == waitLevel)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall   = waitReq && (hs_q != waitLevel);
  assign hsLevel = hs_q;
  assign swData  = data_q;
  assign swValid = valid_q;
  assign waiting = (state_q == WAITING);

endmodule

// File: tb/tb_sw_handshake_ctrl.sv
// Directed bench for sw_handshake_ctrl with DEBOUNCE = 4 (hsLevel flips on the 6th edge).
module tb_sw_handshake_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] switchesIn;
  logic       waitReq, waitLevel;
  logic       stall, hsLevel, swValid, waiting;
  logic [7:0] swData;

  int checks = 0;
  int errors = 0;

  sw_handshake_ctrl #(.N(8), .HS_BIT(8), .DEBOUNCE(4)) dut (
    .clk(clk), .reset(reset), .switchesIn(switchesIn),
    .waitReq(waitReq), .waitLevel(waitLevel),
    .stall(stall), .hsLevel(hsLevel), .swData(swData),
    .swValid(swValid), .waiting(waiting)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; switchesIn = '0; waitReq = 1'b0; waitLevel = 1'b0;
    #12;
    checks++; if (stall !== 1'b0)   begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (hsLevel !== 1'b0) begin errors++; $display("FAIL reset_hs got %b exp 0", hsLevel); end
    checks++; if (swData !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", swData); end
    checks++; if (swValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", swValid); end
    checks++; if (waiting !== 1'b0) begin errors++; $display("FAIL reset_waiting got %b exp 0", waiting); end
    waitReq = 1'b1; waitLevel = 1'b1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall_comb got %b exp 1", stall); end
    waitReq = 1'b0; waitLevel = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_capture();
    switchesIn = 10'h1A5;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (hsLevel !== 1'b0 || swValid !== 1'b0) begin
        errors++; $display("FAIL cap_early edge%0d hs %b valid %b exp 0 0", i, hsLevel, swValid); end
    end
    tick();
    checks++; if (hsLevel !== 1'b1) begin errors++; $display("FAIL cap_hs got %b exp 1", hsLevel); end
    checks++; if (swData !== 8'hA5) begin errors++; $display("FAIL cap_data got %h exp a5", swData); end
    checks++; if (swValid !== 1'b1) begin errors++; $display("FAIL cap_valid got %b exp 1", swValid); end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (swValid !== 1'b0) begin errors++; $display("FAIL cap_hold_valid cyc%0d got %b exp 0", i, swValid); end
    end
    // falling handshake with new data: no capture
    switchesIn = 10'h05A;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (hsLevel !== 1'b0) begin errors++; $display("FAIL fall_hs got %b exp 0", hsLevel); end
    checks++; if (swData !== 8'hA5 || swValid !== 1'b0) begin
      errors++; $display("FAIL fall_nocap data %h valid %b exp a5 0", swData, swValid); end
    switchesIn = '0;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_glitch();
    switchesIn = 10'h100;
    for (int i = 0; i < 3; i++) tick();
    switchesIn = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (hsLevel !== 1'b0 || swValid !== 1'b0) begin
        errors++; $display("FAIL glitch cyc%0d hs %b valid %b exp 0 0", i, hsLevel, swValid); end
    end
    checks++; if (dut.cnt_q !== 3'd0) begin errors++; $display("FAIL glitch_cnt got %0d exp 0", dut.cnt_q); end
  endtask

  task automatic test_wait_rise();
    waitReq = 1'b1; waitLevel = 1'b1; switchesIn = 10'h13C;
    #1;
    checks++; if (stall !== 1'b1 || waiting !== 1'b0) begin
      errors++; $display("FAIL wait_start stall %b waiting %b exp 1 0", stall, waiting); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (stall !== 1'b1 || waiting !== 1'b1) begin
        errors++; $display("FAIL wait_hold edge%0d stall %b waiting %b exp 1 1", i, stall, waiting); end
    end
    tick();
    checks++; if (stall !== 1'b0 || hsLevel !== 1'b1) begin
      errors++; $display("FAIL wait_release stall %b hs %b exp 0 1", stall, hsLevel); end
    checks++; if (swData !== 8'h3C || swValid !== 1'b1) begin
      errors++; $display("FAIL wait_data data %h valid %b exp 3c 1", swData, swValid); end
    checks++; if (waiting !== 1'b1) begin errors++; $display("FAIL wait_flag_lag got %b exp 1", waiting); end
    tick();
    checks++; if (waiting !== 1'b0) begin errors++; $display("FAIL wait_clear got %b exp 0", waiting); end
    // a following wait already satisfied: no stall, FSM stays idle
    tick();
    checks++; if (stall !== 1'b0 || waiting !== 1'b0) begin
      errors++; $display("FAIL b2b stall %b waiting %b exp 0 0", stall, waiting); end
    waitReq = 1'b0;
  endtask

  task automatic test_wait_drop();
    waitReq = 1'b1; waitLevel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL drop_stall cyc%0d got %b exp 1", i, stall); end
      tick();
    end
    waitReq = 1'b0; #1;
    checks++; if (stall !== 1'b0 || waiting !== 1'b1) begin
      errors++; $display("FAIL drop_comb stall %b waiting %b exp 0 1", stall, waiting); end
    tick();
    checks++; if (waiting !== 1'b0) begin errors++; $display("FAIL drop_waiting got %b exp 0", waiting); end
    switchesIn = '0;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (hsLevel !== 1'b0) begin errors++; $display("FAIL drop_hs_low got %b exp 0", hsLevel); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    switchesIn = 10'h1C3;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (dut.cnt_q !== 3'd2) begin errors++; $display("FAIL mid_cnt got %0d exp 2", dut.cnt_q); end
    reset = 1'b1; #1;
    checks++; if (swData !== 8'h00 || hsLevel !== 1'b0 || swValid !== 1'b0 || waiting !== 1'b0) begin
      errors++; $display("FAIL mid_reset data %h hs %b valid %b waiting %b exp 00 0 0 0", swData, hsLevel, swValid, waiting); end
    tick(); tick();
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (hsLevel !== 1'b0) begin errors++; $display("FAIL mid_early edge%0d got %b exp 0", i, hsLevel); end
    end
    tick();
    checks++; if (hsLevel !== 1'b1 || swValid !== 1'b1 || swData !== 8'hC3) begin
      errors++; $display("FAIL mid_capture hs %b valid %b data %h exp 1 1 c3", hsLevel, swValid, swData); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (swValid) pulses++; end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_single_pulse extra %0d exp 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_glitch();
    test_wait_rise();
    test_wait_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_handshake_ctrl.md
# sw_handshake_ctrl

Switch-handshake sequencer between the board switches and the picoMIPS control/data paths. It synchronises and debounces the handshake switch and synchronises the data switches. It captures the input byte on each debounced handshake rising edge. It stalls the program counter while a wait-for-handshake instruction is pending.

## Interface
Parameters:
- N, 8, data width; the data switches are switchesIn[N-1:0].
- HS_BIT, 8, index of the handshake switch in switchesIn.
- DEBOUNCE, 4, consecutive stable cycles required before the debounced level flips (≥1). The counter width is $clog2(DEBOUNCE+1).

Ports:
- clk  in  1  system clock; all state is updated on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- switchesIn  in  10  raw board switches, asynchronous to clk.
- waitReq  in  1  from controlPath: the current instruction is a wait-for-handshake.
- waitLevel  in  1  handshake level the instruction waits for (1 = switch on, 0 = switch off).
- stall  out  1  hold the PC and suppress register write-back this cycle.
- hsLevel  out  1  debounced handshake level.
- swData  out  N  last captured data byte.
- swValid  out  1  one-cycle pulse: swData was updated at the previous edge.
- waiting  out  1  registered; the FSM is in WAITING.

## Operation
- Synchroniser: all 10 switch bits pass through a 2-FF chain (s1, then s2). Only s2 is used downstream.
- Debounce, applied to the handshake bit only:
  - The counter cnt clears whenever s2[HS_BIT] == hsLevel.
  - Otherwise cnt increments.
  - If the bits differ and cnt == DEBOUNCE-1, hsLevel toggles at that edge and cnt clears.
  - A disagreement shorter than DEBOUNCE cycles at s2 never changes hsLevel.
- Capture:
  - At the edge where hsLevel goes 0→1, swData <= s2[N-1:0] and swValid <= 1.
  - At every other edge, swValid <= 0.
  - A 1→0 transition captures nothing.
- Stall is combinational: stall = waitReq && (hsLevel != waitLevel).
  - The wait instruction completes in the first cycle where hsLevel == waitLevel.
  - Back-to-back wait instructions are each evaluated against the current hsLevel. No state is consumed by a completed wait.
- FSM with 2 states:
  - IDLE→WAITING when waitReq && hsLevel != waitLevel at an edge.
  - WAITING→IDLE when !waitReq or hsLevel == waitLevel at an edge.
  - In every other case the FSM holds its state.
  - waiting = (state == WAITING).
- Data bits are sampled only at the hsLevel rising edge. Data changes while the handshake is high have no effect until the next rising edge.

## Timing
- Reset (asynchronous, immediate): s1 = s2 = 0, cnt = 0, hsLevel = 0, swData = 0, swValid = 0, state = IDLE, waiting = 0.
- During reset, stall = waitReq && waitLevel, because hsLevel = 0.
- Latency, for a handshake change stable before edge 0:
  - hsLevel flips at edge DEBOUNCE+1, i.e. the (DEBOUNCE+2)th rising edge. With the default DEBOUNCE = 4 this is the 6th edge.
  - swValid is high in the cycle after that edge.
  - stall drops in the same cycle that hsLevel matches waitLevel (0 cycles after the flip).
- Glitch: s2 differing for k < DEBOUNCE cycles, then returning, leaves hsLevel unchanged and clears cnt.
- Reset mid-operation: all state clears; there is no partial capture. If the handshake switch is still high after reset releases:
  - hsLevel rises DEBOUNCE+2 edges later;
  - a fresh capture with swValid occurs. This is required behaviour.
- waitReq dropping while WAITING: stall falls immediately (combinational); waiting falls at the next edge.
- waitReq asserting in the same cycle hsLevel flips to match waitLevel: stall = 0 and the FSM stays in IDLE.
- swValid pulses are separated by at least 2·DEBOUNCE cycles, because a full on→off→on handshake is needed.

## Test plan
- Reset with all switches 0, waitReq = 0: every output is 0, including stall.
- SW = 10'h1A5 held from edge 0: hsLevel = 1 and swData = 8'hA5 after the 6th edge; swValid = 1 for exactly one cycle; no second pulse while held.
- Handshake switch pulsed high for 3 cycles (DEBOUNCE = 4): hsLevel stays 0, swValid stays 0, cnt returns to 0.
- waitReq = 1, waitLevel = 1 with the switch off, then SW = 10'h13C:
  - stall = 1 and waiting = 1 until hsLevel rises;
  - stall = 0 in that cycle;
  - swData = 8'h3C; waiting clears at the next edge.
- Reset asserted mid-debounce (cnt = 2) with the handshake still high, then released: outputs clear immediately; hsLevel rises 6 edges after release with a single swValid pulse.
- waitReq = 1, waitLevel = 0 while hsLevel = 1, then waitReq dropped after 5 cycles: stall is 1 for 5 cycles, then 0 combinationally; waiting clears at the next edge.
